led_step_sequencer: RTL and testbench

- Timed step generator that produces the step index `a[3:0]` and direction bit `E` consumed by the LED bar decoder on the DE10-Lite LED sequencer.
- Board switches for run, direction and clear are synchronised, and a prescaler divides the 50 MHz clock down to a visible step rate.
- The index advances, wraps (or ping-pongs, optionally) and is held on pause under a small FSM.
- Sits between the switch inputs and the decoder's `E` and `a` inputs.

---
 rtl/led_step_sequencer.sv | 148 ++++++++++++++
 tb/tb_led_step_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/led_step_sequencer.sv
// led_step_sequencer: timed step generator for the DE10-Lite LED bar decoder.
// Synchronises the run/dir/clr switches, divides clk down to the step rate and
// advances a wrapping step index. Defining LED_SEQ_PINGPONG_EN switches the
// index to bounce between 0 and LAST_STEP, with E latched at run start.
module led_step_sequencer #(
    parameter int unsigned TICKS_PER_STEP = 5000000,
    parameter int unsigned LAST_STEP      = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       dir,
    input  logic       clr,
    output logic [3:0] a,
    output logic       E,
    output logic       step,
    output logic       at_end
);

    localparam int unsigned PW     = $clog2(TICKS_PER_STEP);
    localparam logic [PW-1:0] PS_MAX = PW'(TICKS_PER_STEP - 1);
    localparam logic [3:0]    LAST   = 4'(LAST_STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state_q;
    logic [1:0]    run_sync_q;
    logic [1:0]    dir_sync_q;
    logic [1:0]    clr_sync_q;
    logic [PW-1:0] presc_q;
    logic [3:0]    a_q;
    logic          e_q;
    logic          step_q;
    logic          at_end_q;

    logic          run_s;
    logic          dir_s;
    logic          clr_s;
    logic [3:0]    adv_a_d;
    logic          adv_e_d;

    assign run_s  = run_sync_q[1];
    assign dir_s  = dir_sync_q[1];
    assign clr_s  = clr_sync_q[1];

    assign a      = a_q;
    assign E      = e_q;
    assign step   = step_q;
    assign at_end = at_end_q;

    // Next index and direction for one advance on a tick.
    always_comb begin
        adv_a_d = a_q;
        adv_e_d = e_q;
`ifdef LED_SEQ_PINGPONG_EN
        if (e_q) begin
            if (a_q == LAST) begin
                adv_e_d = 1'b0;
                adv_a_d = LAST - 4'd1;
            end else begin
                adv_a_d = a_q + 4'd1;
            end
        end else begin
            if (a_q == 4'd0) begin
                adv_e_d = 1'b1;
                adv_a_d = 4'd1;
            end else begin
                adv_a_d = a_q - 4'd1;
            end
        end
`else
        adv_e_d = dir_s;
        if (dir_s) begin
            adv_a_d = (a_q == LAST) ? 4'd0 : a_q + 4'd1;
        end else begin
            adv_a_d = (a_q == 4'd0) ? LAST : a_q - 4'd1;
        end
`endif
    end

    // Switch synchronisers, prescaler and step FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_sync_q <= 2'b00;
            dir_sync_q <= 2'b00;
            clr_sync_q <= 2'b00;
            state_q    <= IDLE;
            presc_q    <= '0;
            a_q        <= 4'd0;
            e_q        <= 1'b0;
            step_q     <= 1'b0;
            at_end_q   <= 1'b0;
        end else begin
            run_sync_q <= {run_sync_q[0], run};
            dir_sync_q <= {dir_sync_q[0], dir};
            clr_sync_q <= {clr_sync_q[0], clr};
            step_q     <= 1'b0;

            if (clr_s) begin
                // Clear wins over any tick and parks the sequencer in IDLE.
                state_q  <= IDLE;
                presc_q  <= '0;
                a_q      <= 4'd0;
                e_q      <= dir_s;
                at_end_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        presc_q  <= '0;
                        a_q      <= 4'd0;
                        e_q      <= dir_s;
                        at_end_q <= 1'b0;
                        if (run_s) begin
                            state_q <= RUN;
                        end
                    end
                    RUN: begin
                        if (!run_s) begin
                            // Pause freezes the prescaler, even on a tick.
                            state_q <= HOLD;
                        end else if (presc_q == PS_MAX) begin
                            presc_q  <= '0;
                            a_q      <= adv_a_d;
                            e_q      <= adv_e_d;
                            step_q   <= 1'b1;
                            at_end_q <= (adv_a_d == LAST);
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
                    end
                    HOLD: begin
                        if (run_s) begin
                            state_q <= RUN;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_step_sequencer.sv
// Self-checking bench for led_step_sequencer (TICKS_PER_STEP=4, LAST_STEP=9).
// Directed scenarios followed by random switch activity, all checked each
// cycle against a behavioural model of the step sequence.
module tb_led_step_sequencer;

    localparam int unsigned T    = 4;
    localparam int unsigned LAST = 9;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       dir;
    logic       clr;
    logic [3:0] a;
    logic       E;
    logic       step;
    logic       at_end;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Behavioural model: mode 0=idle, 1=running, 2=paused.
    int unsigned m_mode = 0;
    int unsigned m_pos  = 0;
    int unsigned m_el   = 0;
    bit          m_e    = 1'b0;
    bit          m_step = 1'b0;
    bit [1:0]    h_run  = 2'b00;
    bit [1:0]    h_dir  = 2'b00;
    bit [1:0]    h_clr  = 2'b00;

    always #5 clk = ~clk;

    led_step_sequencer #(
        .TICKS_PER_STEP(T),
        .LAST_STEP     (LAST)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .dir   (dir),
        .clr   (clr),
        .a     (a),
        .E     (E),
        .step  (step),
        .at_end(at_end)
    );

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One step of the index: wrap (default) or bounce (ping-pong).
    task automatic model_advance(input bit ds);
`ifdef LED_SEQ_PINGPONG_EN
        if (m_e) begin
            if (m_pos == LAST) begin m_e = 1'b0; m_pos = LAST - 1; end
            else m_pos = m_pos + 1;
        end else begin
            if (m_pos == 0) begin m_e = 1'b1; m_pos = 1; end
            else m_pos = m_pos - 1;
        end
`else
        m_e = ds;
        if (m_e) m_pos = (m_pos + 1) % (LAST + 1);
        else     m_pos = (m_pos + LAST) % (LAST + 1);
`endif
    endtask

    // Model reaction to one rising edge, using the inputs present at that edge.
    task automatic model_edge();
        bit rs;
        bit ds;
        bit cs;
        rs = h_run[1];
        ds = h_dir[1];
        cs = h_clr[1];
        m_step = 1'b0;
        if (rst) begin
            m_mode = 0; m_pos = 0; m_el = 0; m_e = 1'b0;
            h_run = 2'b00; h_dir = 2'b00; h_clr = 2'b00;
        end else begin
            if (cs) begin
                m_mode = 0; m_pos = 0; m_el = 0; m_e = ds;
            end else if (m_mode == 0) begin
                m_pos = 0; m_el = 0; m_e = ds;
                if (rs) m_mode = 1;
            end else if (m_mode == 1) begin
                if (!rs) begin
                    m_mode = 2;
                end else if (m_el == T - 1) begin
                    m_el = 0;
                    model_advance(ds);
                    m_step = 1'b1;
                end else begin
                    m_el = m_el + 1;
                end
            end else begin
                if (rs) m_mode = 1;
            end
            h_run = {h_run[0], run};
            h_dir = {h_dir[0], dir};
            h_clr = {h_clr[0], clr};
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_val("a", a, m_pos);
        check_val("E", E, m_e);
        check_val("step", step, m_step);
        check_val("at_end", at_end, (m_pos == LAST) ? 1 : 0);
    endtask

    task automatic set_in(input logic r, input logic d, input logic c);
        run = r;
        dir = d;
        clr = c;
    endtask

    initial begin
        int budget;
        rst = 1'b1;
        set_in(1'b1, 1'b1, 1'b1);

        // Reset with all switches high.
        cycle();
        cycle();
        check_val("rst_a", a, 0);
        check_val("rst_E", E, 0);
        check_val("rst_step", step, 0);
        check_val("rst_at_end", at_end, 0);

        // Up wrap: release reset and count up.
        rst = 1'b0;
        set_in(1'b1, 1'b1, 1'b0);
        repeat (48) cycle();

        // Down wrap from IDLE.
        set_in(1'b0, 1'b0, 1'b1);
        repeat (3) cycle();
        set_in(1'b1, 1'b0, 1'b0);
        repeat (48) cycle();

        // Pause at a=5 mid-interval, then resume.
        set_in(1'b0, 1'b1, 1'b1);
        repeat (3) cycle();
        set_in(1'b1, 1'b1, 1'b0);
        budget = 300;
        while (!(m_pos == 5 && m_el == 1 && m_mode == 1) && budget > 0) begin
            cycle();
            budget--;
        end
        check_val("pause_at_a5", a, 5);
        run = 1'b0;
        repeat (20) cycle();
        check_val("pause_hold_a", a, 5);
        run = 1'b1;
        repeat (12) cycle();

        // Clear arriving at the synchronised side on the tick at a=7.
        budget = 300;
        while (!(m_pos == 7 && m_el == 1 && m_mode == 1) && budget > 0) begin
            cycle();
            budget--;
        end
        check_val("clr_pre_a7", a, 7);
        clr = 1'b1;
        repeat (3) cycle();
        check_val("clr_tick_a", a, 0);
        check_val("clr_tick_step", step, 0);
        repeat (6) cycle();
        check_val("clr_idle_a", a, 0);
        clr = 1'b0;
        repeat (20) cycle();

        // Random switch activity with occasional clear and reset.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15) == 0) run = ~run;
            if ($urandom_range(7) == 0)  dir = ~dir;
            clr = ($urandom_range(63) == 0) ? 1'b1 : (clr && ($urandom_range(3) != 0));
            rst = ($urandom_range(499) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
